// File: rtl/cpu_addr_pkg.sv
// Shared types and constants for the indexed address generator.
package cpu_addr_pkg;

  localparam logic [7:0] ZERO_PAGE = 8'h00;

  // Addressing modes; encodings 6 and 7 are reserved and never accepted.
  typedef enum logic [2:0] {
    MODE_ZPX  = 3'd0,
    MODE_ZPY  = 3'd1,
    MODE_ABSX = 3'd2,
    MODE_ABSY = 3'd3,
    MODE_INDX = 3'd4,
    MODE_INDY = 3'd5
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_OP_LO  = 3'd1,
    ST_OP_HI  = 3'd2,
    ST_PTR_LO = 3'd3,
    ST_PTR_HI = 3'd4,
    ST_FIXUP  = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

  // True for the six defined mode encodings.
  function automatic logic mode_is_valid(input logic [2:0] m);
    return (m <= 3'd5);
  endfunction

  // Y-indexed modes are the odd encodings (ZPY, ABSY, INDY).
  function automatic logic mode_uses_y(input logic [2:0] m);
    return m[0];
  endfunction

endpackage

// File: rtl/page_adder.sv
// 16-bit base plus 8-bit unsigned index; reports carry out of the low byte.
module page_adder (
  input  logic [15:0] base_i,
  input  logic [7:0]  index_i,
  output logic [15:0] sum_o,
  output logic        carry_o
);

  logic [8:0] lo_sum;

  assign lo_sum  = {1'b0, base_i[7:0]} + {1'b0, index_i};
  assign carry_o = lo_sum[8];
  assign sum_o   = {base_i[15:8] + {7'b0000000, lo_sum[8]}, lo_sum[7:0]};

endmodule

// File: rtl/indexed_address_gen.sv
// Effective-address generator for zero-page, absolute and indirect indexed
// addressing. Operand and pointer bytes arrive on db_in.
//
// Handshake: there is no ready signal. In OP_LO, OP_HI, PTR_LO and PTR_HI the
// block waits indefinitely and consumes db_in on exactly the rising edge where
// db_valid=1; db_valid is ignored in every other state. mem_req/mem_addr are
// level outputs that stay stable for the whole PTR_LO/PTR_HI state.
module indexed_address_gen
  import cpu_addr_pkg::*;
(
  input  logic        fclk,
  input  logic        resb,
  input  logic        start,
  input  logic [2:0]  mode,
  input  logic        force_fix,
  input  logic [7:0]  x_index,
  input  logic [7:0]  y_index,
  input  logic [7:0]  db_in,
  input  logic        db_valid,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  output logic [15:0] ea,
  output logic        ea_valid,
  output logic        busy,
  output logic        page_cross,
  output state_e      dbg_state
);

  state_e      state_q, state_d;
  mode_e       mode_q;
  logic        fix_q;
  logic [7:0]  idx_q;
  logic [7:0]  lo_q;
  logic [7:0]  ptr_q;
  logic [15:0] ea_q;
  logic        pc_q;

  logic [15:0] add_base;
  logic [15:0] add_sum;
  logic        add_carry;
  logic [7:0]  zp_sum;
  logic [7:0]  ptr_inc;
  logic        accept;

  assign accept  = start && mode_is_valid(mode);
  assign zp_sum  = db_in + idx_q;
  assign ptr_inc = ptr_q + 8'd1;

  // High byte arrives on db_in; low byte is either the absolute operand or the pointer data.
  assign add_base = {db_in, lo_q};

  page_adder u_page_adder (
    .base_i  (add_base),
    .index_i (idx_q),
    .sum_o   (add_sum),
    .carry_o (add_carry)
  );

  // State register.
  always_ff @(posedge fclk or negedge resb) begin
    if (!resb) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_OP_LO;
      ST_OP_LO: begin
        if (db_valid) begin
          case (mode_q)
            MODE_ZPX, MODE_ZPY:   state_d = ST_DONE;
            MODE_ABSX, MODE_ABSY: state_d = ST_OP_HI;
            default:              state_d = ST_PTR_LO;
          endcase
        end
      end
      ST_OP_HI:  if (db_valid) state_d = (add_carry || fix_q) ? ST_FIXUP : ST_DONE;
      ST_PTR_LO: if (db_valid) state_d = ST_PTR_HI;
      ST_PTR_HI: begin
        if (db_valid) begin
          if (mode_q == MODE_INDX) state_d = ST_DONE;
          else                     state_d = (add_carry || fix_q) ? ST_FIXUP : ST_DONE;
        end
      end
      ST_FIXUP:  state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    mem_req    = 1'b0;
    mem_addr   = 16'h0000;
    busy       = (state_q != ST_IDLE);
    ea_valid   = (state_q == ST_DONE);
    page_cross = (state_q == ST_DONE) && pc_q;
    case (state_q)
      ST_PTR_LO: begin
        mem_req  = 1'b1;
        mem_addr = {ZERO_PAGE, ptr_q};
      end
      ST_PTR_HI: begin
        mem_req  = 1'b1;
        mem_addr = {ZERO_PAGE, ptr_inc};
      end
      default: ;
    endcase
  end

  assign ea        = ea_q;
  assign dbg_state = state_q;

  // Datapath: latch request fields at start, capture bytes, form the result.
  always_ff @(posedge fclk or negedge resb) begin
    if (!resb) begin
      mode_q <= MODE_ZPX;
      fix_q  <= 1'b0;
      idx_q  <= 8'h00;
      lo_q   <= 8'h00;
      ptr_q  <= 8'h00;
      ea_q   <= 16'h0000;
      pc_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            mode_q <= mode_e'(mode);
            fix_q  <= force_fix;
            idx_q  <= mode_uses_y(mode) ? y_index : x_index;
          end
        end
        ST_OP_LO: begin
          if (db_valid) begin
            lo_q  <= db_in;
            pc_q  <= 1'b0;
            // (zp,X) pre-indexes the pointer; (zp),Y uses the operand as-is.
            ptr_q <= (mode_q == MODE_INDX) ? zp_sum : db_in;
            if (mode_q == MODE_ZPX || mode_q == MODE_ZPY) ea_q <= {ZERO_PAGE, zp_sum};
          end
        end
        ST_OP_HI: begin
          if (db_valid) begin
            ea_q <= add_sum;
            pc_q <= add_carry;
          end
        end
        ST_PTR_LO: if (db_valid) lo_q <= db_in;
        ST_PTR_HI: begin
          if (db_valid) begin
            if (mode_q == MODE_INDX) begin
              ea_q <= {db_in, lo_q};
              pc_q <= 1'b0;
            end else begin
              ea_q <= add_sum;
              pc_q <= add_carry;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_indexed_address_gen.sv
// Directed testbench for indexed_address_gen.
module tb_indexed_address_gen;
  import cpu_addr_pkg::*;

  logic        fclk = 1'b0;
  logic        resb = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic        force_fix = 1'b0;
  logic [7:0]  x_index = 8'h00;
  logic [7:0]  y_index = 8'h00;
  logic [7:0]  db_in = 8'h00;
  logic        db_valid = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] ea;
  logic        ea_valid;
  logic        busy;
  logic        page_cross;
  state_e      dbg_state;

  int n_run = 0;
  int n_fail = 0;

  // Results captured by run_op.
  int          r_lat;
  logic [15:0] r_ea;
  logic        r_pc;
  logic        r_fix;
  logic [15:0] r_addr0;
  logic [15:0] r_addr1;
  int          r_nreq;

  // Clock.
  always #5 fclk = ~fclk;

  indexed_address_gen dut (
    .fclk       (fclk),
    .resb       (resb),
    .start      (start),
    .mode       (mode),
    .force_fix  (force_fix),
    .x_index    (x_index),
    .y_index    (y_index),
    .db_in      (db_in),
    .db_valid   (db_valid),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .ea         (ea),
    .ea_valid   (ea_valid),
    .busy       (busy),
    .page_cross (page_cross),
    .dbg_state  (dbg_state)
  );

  // Driver: issue one operation with db_valid held high, feeding bytes b0..b2
  // in consumption order. Called and returns at posedge+1 with the DUT idle.
  task automatic run_op(input logic [2:0] m, input logic [7:0] x, input logic [7:0] y,
                        input logic ff, input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2);
    logic [7:0] bytes [3];
    int k;
    int cyc;
    bit done;
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
    r_lat = 0; r_ea = 16'h0; r_pc = 1'b0; r_fix = 1'b0;
    r_addr0 = 16'h0; r_addr1 = 16'h0; r_nreq = 0;
    k = 0; done = 1'b0;
    mode = m; x_index = x; y_index = y; force_fix = ff;
    start = 1'b1; db_valid = 1'b1; db_in = 8'h00;
    @(posedge fclk); #1;
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 30) begin
      if (ea_valid) begin
        r_lat = cyc; r_ea = ea; r_pc = page_cross; done = 1'b1;
      end else begin
        if (dbg_state == ST_FIXUP) r_fix = 1'b1;
        if (mem_req) begin
          if (r_nreq == 0) r_addr0 = mem_addr;
          else if (r_nreq == 1) r_addr1 = mem_addr;
          r_nreq++;
        end
        if (dbg_state inside {ST_OP_LO, ST_OP_HI, ST_PTR_LO, ST_PTR_HI}) begin
          db_in = (k < 3) ? bytes[k] : 8'h00;
          k++;
        end
        @(posedge fclk); #1;
        cyc++;
      end
    end
    n_run++;
    if (!done) begin
      n_fail++;
      $display("FAIL run_op_timeout: no ea_valid within %0d cycles (mode %0d)", cyc, m);
    end
    db_valid = 1'b0;
    @(posedge fclk); #1;
  endtask

  task automatic test_reset();
    resb = 1'b0;
    #1;
    n_run++;
    if ({mem_req, mem_addr, ea, ea_valid, busy, page_cross} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got req=%b addr=%h ea=%h v=%b busy=%b pc=%b, need all 0",
               mem_req, mem_addr, ea, ea_valid, busy, page_cross);
    end
    n_run++;
    if (dbg_state !== ST_IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d need %0d", dbg_state, ST_IDLE);
    end
    @(posedge fclk); #1;
    resb = 1'b1;
  endtask

  task automatic test_zp();
    run_op(3'd0, 8'h20, 8'h00, 1'b0, 8'hF0, 8'h00, 8'h00);
    n_run++;
    if (r_ea !== 16'h0010) begin n_fail++; $display("FAIL zpx_ea: got %h need 0010", r_ea); end
    n_run++;
    if (r_pc !== 1'b0) begin n_fail++; $display("FAIL zpx_pc: got %b need 0", r_pc); end
    n_run++;
    if (r_lat != 2) begin n_fail++; $display("FAIL zpx_latency: got %0d need 2", r_lat); end
    run_op(3'd1, 8'h00, 8'h02, 1'b1, 8'hFF, 8'h00, 8'h00);
    n_run++;
    if ({r_ea, r_pc, r_fix} !== {16'h0001, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL zpy_wrap: got ea=%h pc=%b fix=%b need 0001 0 0", r_ea, r_pc, r_fix);
    end
  endtask

  task automatic test_abs();
    run_op(3'd2, 8'hE0, 8'h00, 1'b0, 8'h34, 8'h12, 8'h00);
    n_run++;
    if ({r_ea, r_pc, r_fix} !== {16'h1314, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL absx_carry: got ea=%h pc=%b fix=%b need 1314 1 1", r_ea, r_pc, r_fix);
    end
    n_run++;
    if (r_lat != 4) begin n_fail++; $display("FAIL absx_carry_latency: got %0d need 4", r_lat); end
    run_op(3'd2, 8'h01, 8'h00, 1'b0, 8'h34, 8'h12, 8'h00);
    n_run++;
    if ({r_ea, r_pc, r_fix} !== {16'h1235, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL absx_nocarry: got ea=%h pc=%b fix=%b need 1235 0 0", r_ea, r_pc, r_fix);
    end
    n_run++;
    if (r_lat != 3) begin n_fail++; $display("FAIL absx_nocarry_latency: got %0d need 3", r_lat); end
    run_op(3'd3, 8'h01, 8'h01, 1'b1, 8'h34, 8'h12, 8'h00);
    n_run++;
    if ({r_ea, r_pc, r_fix, r_lat[3:0]} !== {16'h1235, 1'b0, 1'b1, 4'd4}) begin
      n_fail++; $display("FAIL absy_forcefix: got ea=%h pc=%b fix=%b lat=%0d need 1235 0 1 4",
                         r_ea, r_pc, r_fix, r_lat);
    end
  endtask

  task automatic test_indirect();
    run_op(3'd4, 8'h01, 8'h00, 1'b0, 8'hFE, 8'h00, 8'h80);
    n_run++;
    if ({r_addr0, r_addr1} !== {16'h00FF, 16'h0000} || r_nreq != 2) begin
      n_fail++; $display("FAIL indx_ptr_reads: got %h,%h n=%0d need 00ff,0000 n=2", r_addr0, r_addr1, r_nreq);
    end
    n_run++;
    if ({r_ea, r_pc} !== {16'h8000, 1'b0}) begin
      n_fail++; $display("FAIL indx_ea: got ea=%h pc=%b need 8000 0", r_ea, r_pc);
    end
    n_run++;
    if (r_lat != 4) begin n_fail++; $display("FAIL indx_latency: got %0d need 4", r_lat); end
    run_op(3'd5, 8'h00, 8'h05, 1'b1, 8'h40, 8'h10, 8'h20);
    n_run++;
    if ({r_addr0, r_addr1} !== {16'h0040, 16'h0041}) begin
      n_fail++; $display("FAIL indy_ptr_reads: got %h,%h need 0040,0041", r_addr0, r_addr1);
    end
    n_run++;
    if ({r_ea, r_pc, r_fix} !== {16'h2015, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL indy_forcefix: got ea=%h pc=%b fix=%b need 2015 0 1", r_ea, r_pc, r_fix);
    end
    run_op(3'd5, 8'h00, 8'h20, 1'b0, 8'hFF, 8'hF0, 8'h12);
    n_run++;
    if ({r_addr0, r_addr1} !== {16'h00FF, 16'h0000}) begin
      n_fail++; $display("FAIL indy_ptr_wrap: got %h,%h need 00ff,0000", r_addr0, r_addr1);
    end
    n_run++;
    if ({r_ea, r_pc, r_fix, r_lat[3:0]} !== {16'h1310, 1'b1, 1'b1, 4'd5}) begin
      n_fail++; $display("FAIL indy_carry: got ea=%h pc=%b fix=%b lat=%0d need 1310 1 1 5",
                         r_ea, r_pc, r_fix, r_lat);
    end
  endtask

  task automatic test_reserved();
    for (int m = 6; m < 8; m++) begin
      mode = 3'(m); start = 1'b1;
      @(posedge fclk); #1;
      start = 1'b0;
      n_run++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reserved_mode_%0d: busy=%b need 0", m, busy); end
    end
  endtask

  task automatic test_db_wait();
    mode = 3'd3; y_index = 8'h10; x_index = 8'h00; force_fix = 1'b0;
    start = 1'b1; db_valid = 1'b0;
    @(posedge fclk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge fclk); #1; end
    n_run++;
    if (dbg_state !== ST_OP_LO || ea_valid !== 1'b0) begin
      n_fail++; $display("FAIL wait_op_lo: state=%0d v=%b need %0d 0", dbg_state, ea_valid, ST_OP_LO);
    end
    db_valid = 1'b1; db_in = 8'hF8;
    @(posedge fclk); #1;
    db_valid = 1'b0;
    repeat (2) begin @(posedge fclk); #1; end
    n_run++;
    if (dbg_state !== ST_OP_HI) begin
      n_fail++; $display("FAIL wait_op_hi: state=%0d need %0d", dbg_state, ST_OP_HI);
    end
    db_valid = 1'b1; db_in = 8'h01;
    @(posedge fclk); #1;
    db_valid = 1'b0;
    @(posedge fclk); #1;
    n_run++;
    if ({ea_valid, ea, page_cross} !== {1'b1, 16'h0208, 1'b1}) begin
      n_fail++; $display("FAIL wait_result: v=%b ea=%h pc=%b need 1 0208 1", ea_valid, ea, page_cross);
    end
    @(posedge fclk); #1;
  endtask

  task automatic test_back_to_back();
    mode = 3'd0; x_index = 8'h01; force_fix = 1'b0; db_in = 8'h05; db_valid = 1'b1;
    start = 1'b1;
    @(posedge fclk); #1;
    @(posedge fclk); #1;
    n_run++;
    if ({ea_valid, ea} !== {1'b1, 16'h0006}) begin
      n_fail++; $display("FAIL b2b_first: v=%b ea=%h need 1 0006", ea_valid, ea);
    end
    @(posedge fclk); #1;
    n_run++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_start_in_done: busy=%b need 0", busy); end
    @(posedge fclk); #1;
    start = 1'b0;
    n_run++;
    if (dbg_state !== ST_OP_LO) begin
      n_fail++; $display("FAIL b2b_restart: state=%0d need %0d", dbg_state, ST_OP_LO);
    end
    repeat (2) begin @(posedge fclk); #1; end
    db_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int guard;
    bit bad_valid;
    mode = 3'd4; x_index = 8'h00; force_fix = 1'b0; db_valid = 1'b1; db_in = 8'h10;
    start = 1'b1;
    @(posedge fclk); #1;
    start = 1'b0; db_in = 8'h11;
    guard = 0;
    while (dbg_state !== ST_PTR_HI && guard < 10) begin @(posedge fclk); #1; guard++; end
    n_run++;
    if (dbg_state !== ST_PTR_HI) begin
      n_fail++; $display("FAIL midreset_reach_ptr_hi: state=%0d need %0d", dbg_state, ST_PTR_HI);
    end
    #1;
    resb = 1'b0;
    #1;
    n_run++;
    if ({mem_req, mem_addr, ea, ea_valid, busy, page_cross} !== 36'h0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got req=%b addr=%h ea=%h v=%b busy=%b pc=%b, need all 0",
               mem_req, mem_addr, ea, ea_valid, busy, page_cross);
    end
    bad_valid = 1'b0;
    repeat (2) begin @(posedge fclk); #1; if (ea_valid || busy) bad_valid = 1'b1; end
    resb = 1'b1;
    n_run++;
    if (bad_valid) begin n_fail++; $display("FAIL midreset_hold: activity seen during reset, need none"); end
    db_valid = 1'b0;
    run_op(3'd1, 8'h00, 8'h03, 1'b0, 8'h05, 8'h00, 8'h00);
    n_run++;
    if ({r_ea, r_pc, r_lat[3:0]} !== {16'h0008, 1'b0, 4'd2}) begin
      n_fail++; $display("FAIL midreset_zpy: got ea=%h pc=%b lat=%0d need 0008 0 2", r_ea, r_pc, r_lat);
    end
  endtask

  initial begin
    test_reset();
    test_zp();
    test_abs();
    test_indirect();
    test_reserved();
    test_db_wait();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/indexed_address_gen.md
INDEXED_ADDRESS_GEN -- requirements
Module: indexed_address_gen

Interface
REQ-001: The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002: fclk  input  1  system clock; all state changes on rising edge.
REQ-003: resb  input  1  asynchronous active-low reset.
REQ-004: start  input  1  begin address generation; sampled only in IDLE.
REQ-005: mode  input  3  0 ZPX, 1 ZPY, 2 ABSX, 3 ABSY, 4 INDX (zp,X), 5 INDY (zp),Y; 6-7 reserved.
REQ-006: force_fix  input  1  write/RMW access; forces the fixup cycle on ABSX/ABSY/INDY; sampled with start.
REQ-007: x_index, y_index  input  8 each  current X/Y index register values; sampled with start.
REQ-008: db_in  input  8  operand byte or memory read data.
REQ-009: db_valid  input  1  db_in holds valid data this cycle.
REQ-010: mem_req  output  1  request memory read at mem_addr (pointer fetch).
REQ-011: mem_addr  output  16  pointer read address.
REQ-012: ea  output  16  effective address; valid while ea_valid=1, holds value until next start.
REQ-013: ea_valid  output  1  single-cycle completion pulse.
REQ-014: busy  output  1  high in every state except IDLE.
REQ-015: page_cross  output  1  high with ea_valid when low-byte index add carried.

Function
REQ-016: States SHALL be IDLE, OP_LO, OP_HI, PTR_LO, PTR_HI, FIXUP, DONE.
REQ-017: IDLE + start + mode 0-5 -> OP_LO, latching mode, force_fix, selected index (X for 0,2,4; Y for 1,3,5); mode 6-7 ignored, stays IDLE.
REQ-018: OP_LO, OP_HI, PTR_LO, PTR_HI SHALL wait indefinitely while db_valid=0 and capture db_in on the edge where db_valid=1.
REQ-019: ZPX/ZPY: OP_LO -> DONE; ea = {8'h00, (op_lo + idx) mod 256} (zero-page wrap, no page_cross).
REQ-020: ABSX/ABSY: OP_LO -> OP_HI -> (FIXUP if low-byte carry or force_fix, else DONE); ea = {op_hi,op_lo} + idx mod 65536.
REQ-021: INDX: OP_LO -> PTR_LO -> PTR_HI -> DONE; ptr = (op_lo + X) mod 256; PTR_LO reads {00,ptr}, PTR_HI reads {00,(ptr+1) mod 256}; ea = {hi,lo}, no index add.
REQ-022: INDY: OP_LO -> PTR_LO -> PTR_HI -> (FIXUP if carry or force_fix, else DONE); PTR_LO reads {00,op_lo}, PTR_HI reads {00,(op_lo+1) mod 256}; ea = {hi,lo} + Y.
REQ-023: mem_req SHALL be 1 exactly in PTR_LO/PTR_HI with mem_addr as above; mem_addr SHALL be 0 otherwise.
REQ-024: FIXUP SHALL last exactly one cycle then DONE; DONE lasts one cycle (ea_valid=1) then IDLE.
REQ-025: start during any non-IDLE state, including DONE, SHALL be ignored; earliest new start is the cycle after DONE.
REQ-026: Minimum latency start-edge to ea_valid with db_valid held high: ZPX 2, ABSX no carry 3, ABSX carry 4, INDX 4, INDY carry 5 cycles.
REQ-027: page_cross SHALL be 0 when fixup is caused only by force_fix.

Reset
REQ-028: resb=0 SHALL immediately force IDLE and drive mem_req, mem_addr, ea, ea_valid, busy, page_cross to 0, including mid-operation; no partial result is ever reported.
REQ-029: After resb release, the first start is accepted on the next rising edge.

Structure
REQ-030: Shared package cpu_addr_pkg SHALL hold the mode enum, state enum and ZERO_PAGE constant 8'h00.
REQ-031: One sub-module page_adder SHALL compute 16-bit base + 8-bit index, outputting sum and low-byte carry; used for ABS and INDY.

Verification
REQ-032: ZPX, op 8'hF0, X=8'h20, db_valid high -> ea=16'h0010, page_cross=0, ea_valid 2 cycles after start.
REQ-033: ABSX, bytes 34,12, X=8'hE0 -> FIXUP taken, ea=16'h1314, page_cross=1; with X=8'h01 -> ea=16'h1235, no FIXUP.
REQ-034: INDX, op 8'hFE, X=8'h01 -> reads 00FF then 0000 (wrap), returned 00,80 -> ea=16'h8000.
REQ-035: INDY, op 8'h40, ptr data 10,20, Y=8'h05, force_fix=1 -> FIXUP taken, ea=16'h2015, page_cross=0.
REQ-036: resb pulsed low in PTR_HI, then start ZPY op 8'h05 Y=8'h03 -> all outputs 0 during reset, ea=16'h0008, no ea_valid for aborted op.
